// File: rtl/uart_rx_if.sv
// Host-side and line-side signals of the UART receiver.
// The receiver takes the slave view; whoever drives the line and reads the byte takes master.
interface uart_rx_if;
   logic       rx;
   logic       rd_en;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       busy;
   logic       frame_err;
   logic       overrun;

   modport slave (
      input  rx,
      input  rd_en,
      output rx_data,
      output rx_ready,
      output busy,
      output frame_err,
      output overrun
   );

   modport master (
      output rx,
      output rd_en,
      input  rx_data,
      input  rx_ready,
      input  busy,
      input  frame_err,
      input  overrun
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling driven by a
// per-bit cycle counter, one-entry output register with ready/read handshake,
// framing-error pulse and sticky overrun flag.
module uart_rx #(
   parameter int CLKS_PER_BIT = 16   // even, >= 4
) (
   input  logic      clk,
   input  logic      rst_n,
   uart_rx_if.slave  bus
);

   localparam int H  = CLKS_PER_BIT / 2;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(H - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BRK   = 3'd4
   } state_e;

   logic [1:0]    sync_q;
   logic          rx_s;
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          ready_q, ready_d;
   logic          ovr_q, ovr_d;
   logic          ferr_q;

   logic          cnt_mid, cnt_last;
   logic          cnt_clr, bit_clr, sample, commit, stop_bad, busy;

   assign rx_s     = sync_q[1];
   assign cnt_mid  = (cnt_q == CNT_MID);
   assign cnt_last = (cnt_q == CNT_LAST);

   // Two-stage synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b11;
      else        sync_q <= {sync_q[0], bus.rx};
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next state: start check at mid start bit, then one sample per bit period.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!rx_s) state_d = START;
         START:   if (cnt_mid) state_d = rx_s ? IDLE : DATA;
         DATA:    if (cnt_last && (bit_q == 3'd7)) state_d = STOP;
         STOP:    if (cnt_last) state_d = rx_s ? IDLE : BRK;
         BRK:     if (rx_s) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: counter control, sample/commit strobes and busy.
   always_comb begin
      cnt_clr  = 1'b0;
      bit_clr  = 1'b0;
      sample   = 1'b0;
      commit   = 1'b0;
      stop_bad = 1'b0;
      busy     = (state_q != IDLE);
      case (state_q)
         IDLE:  cnt_clr = 1'b1;
         START: begin
            if (cnt_mid) begin
               cnt_clr = 1'b1;
               bit_clr = 1'b1;
            end
         end
         DATA: begin
            if (cnt_last) begin
               cnt_clr = 1'b1;
               sample  = 1'b1;
            end
         end
         STOP: begin
            if (cnt_last) begin
               cnt_clr  = 1'b1;
               commit   = rx_s;
               stop_bad = ~rx_s;
            end
         end
         // BRK only waits for the line to return high; the counter stays parked.
         default: cnt_clr = 1'b1;
      endcase
   end

   // Bit timer, bit index and LSB-first shift register next values.
   always_comb begin
      cnt_d = cnt_clr ? '0 : cnt_q + 1'b1;
      bit_d = bit_q;
      if (bit_clr)     bit_d = 3'd0;
      else if (sample) bit_d = (bit_q == 3'd7) ? 3'd0 : bit_q + 3'd1;
      shift_d = sample ? {rx_s, shift_q[7:1]} : shift_q;
   end

   // Bit timer, bit index and shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
      end else begin
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   // Holding register: a commit beats a coincident read, otherwise a commit
   // onto an unread byte is dropped and flagged as overrun.
   always_comb begin
      data_d  = data_q;
      ready_d = ready_q;
      ovr_d   = ovr_q;
      if (commit) begin
         if (!ready_q || bus.rd_en) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            ovr_d   = 1'b0;
         end else begin
            ovr_d   = 1'b1;
         end
      end else if (bus.rd_en && ready_q) begin
         ready_d = 1'b0;
         ovr_d   = 1'b0;
      end
   end

   // Host-visible registers; frame_err is a one-cycle pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= 8'h00;
         ready_q <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         data_q  <= data_d;
         ready_q <= ready_d;
         ovr_q   <= ovr_d;
         ferr_q  <= stop_bad;
      end
   end

   assign bus.rx_data   = data_q;
   assign bus.rx_ready  = ready_q;
   assign bus.overrun   = ovr_q;
   assign bus.frame_err = ferr_q;
   assign bus.busy      = busy;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus randomized frames, checked every
// cycle against a timestamp-based model of the receive rules.
module tb_uart_rx;

   localparam int C = 16;
   localparam int H = C / 2;

   logic clk = 1'b0;
   logic rst_n;
   logic rx;
   logic rd_en;

   uart_rx_if bus();
   assign bus.rx    = rx;
   assign bus.rd_en = rd_en;

   uart_rx #(.CLKS_PER_BIT(C)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Tracks the edge D at which the idle line is seen low and decides every
   // action purely from the offset t-D versus the sampling points.
   int         t = 0, m_d = 0, off, k;
   int         m_mode = 0;          // 0 idle, 1 in frame, 2 waiting for line high
   logic       m_s1 = 1'b1, m_s2 = 1'b1, rxs;
   logic [7:0] m_byte = 8'h00, m_data = 8'h00;
   logic       m_ready = 1'b0, m_ovr = 1'b0, m_fe = 1'b0;
   bit         m_commit;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1 = 1'b1; m_s2 = 1'b1; m_mode = 0; m_byte = 8'h00; m_data = 8'h00;
         m_ready = 1'b0; m_ovr = 1'b0; m_fe = 1'b0; t = 0;
      end else begin
         rxs = m_s2; m_s2 = m_s1; m_s1 = rx;
         m_commit = 1'b0;
         m_fe = 1'b0;
         case (m_mode)
            0: if (!rxs) begin m_mode = 1; m_d = t; end
            1: begin
               off = t - m_d;
               if (off == H) begin
                  if (rxs) m_mode = 0;
               end else if (off > H && ((off - H) % C) == 0) begin
                  k = (off - H) / C;
                  if (k <= 8) m_byte[k-1] = rxs;
                  else if (rxs) begin m_commit = 1'b1; m_mode = 0; end
                  else begin m_fe = 1'b1; m_mode = 2; end
               end
            end
            default: if (rxs) m_mode = 0;
         endcase
         if (m_commit) begin
            if (!m_ready || rd_en) begin m_data = m_byte; m_ready = 1'b1; m_ovr = 1'b0; end
            else m_ovr = 1'b1;
         end else if (rd_en && m_ready) begin
            m_ready = 1'b0; m_ovr = 1'b0;
         end
         t++;
      end
   end

   // ---------------- checking ----------------
   int         n_chk = 0, n_err = 0, fe_cnt = 0;
   int         lit_wr = 0, lit_rd = 0;
   int         lit_sel [128];
   logic [7:0] lit_exp [128];

   function automatic string sel_name(input int s);
      case (s)
         0: return "lit_rx_data";
         1: return "lit_rx_ready";
         2: return "lit_overrun";
         3: return "lit_frame_err";
         4: return "lit_busy";
         default: return "lit_frame_err_pulses";
      endcase
   endfunction

   function automatic logic [7:0] sel_val(input int s);
      case (s)
         0: return bus.rx_data;
         1: return {7'd0, bus.rx_ready};
         2: return {7'd0, bus.overrun};
         3: return {7'd0, bus.frame_err};
         4: return {7'd0, bus.busy};
         default: return fe_cnt[7:0];
      endcase
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %02h expected %02h", nm, $time, act, exp);
      end
   endtask

   // Single compare process: pending literal expectations, then the model.
   always begin
      @(negedge clk);
      #1;
      while (lit_rd != lit_wr) begin
         chk(sel_name(lit_sel[lit_rd]), sel_val(lit_sel[lit_rd]), lit_exp[lit_rd]);
         lit_rd++;
      end
      if (rst_n) begin
         chk("rx_data",   bus.rx_data,          m_data);
         chk("rx_ready",  {7'd0, bus.rx_ready}, {7'd0, m_ready});
         chk("overrun",   {7'd0, bus.overrun},  {7'd0, m_ovr});
         chk("frame_err", {7'd0, bus.frame_err},{7'd0, m_fe});
         chk("busy",      {7'd0, bus.busy},     {7'd0, m_mode != 0});
         if (bus.frame_err) fe_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic expect_lit(input int sel, input logic [7:0] e);
      lit_sel[lit_wr] = sel;
      lit_exp[lit_wr] = e;
      lit_wr++;
   endtask

   task automatic tick(input logic r, input logic d);
      @(negedge clk);
      rx    = r;
      rd_en = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, 1'b0);
   endtask

   // Full 160-cycle frame. Stop-bit cycle index 10 is the one whose rising edge
   // is the stop-sample edge (2 sync cycles + H + 9 bit periods after start).
   task automatic send_frame(input logic [7:0] b, input logic stopv,
                             input bit rd_stop, input bit rnd);
      logic bv, dv;
      for (int j = 0; j < 10 * C; j++) begin
         if (j < C)          bv = 1'b0;
         else if (j < 9 * C) bv = b[(j - C) / C];
         else                bv = stopv;
         if (rnd) dv = ($urandom_range(0, 3) == 0);
         else     dv = rd_stop && (j == 9 * C + 10);
         tick(bv, dv);
      end
   endtask

   initial begin
      rst_n = 1'b0; rx = 1'b1; rd_en = 1'b0;
      repeat (3) @(negedge clk);
      expect_lit(0, 8'h00); expect_lit(1, 8'h00); expect_lit(2, 8'h00);
      expect_lit(3, 8'h00); expect_lit(4, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      idle(5);

      // single byte
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      expect_lit(0, 8'hA5); expect_lit(1, 8'h01); expect_lit(3, 8'h00);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b0);
      expect_lit(1, 8'h00);

      // start-bit glitch
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
      idle(20);
      expect_lit(4, 8'h00); expect_lit(1, 8'h00); expect_lit(3, 8'h00); expect_lit(5, 8'h00);

      // framing error, line held low, then a good frame
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) tick(1'b0, 1'b0);
      expect_lit(4, 8'h01); expect_lit(1, 8'h00); expect_lit(5, 8'h01);
      idle(5);
      expect_lit(4, 8'h00);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
      expect_lit(0, 8'h3C); expect_lit(1, 8'h01);
      tick(1'b1, 1'b1); tick(1'b1, 1'b0);

      // overrun
      send_frame(8'h11, 1'b1, 1'b0, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0, 1'b0);
      expect_lit(2, 8'h01); expect_lit(0, 8'h11); expect_lit(1, 8'h01);
      tick(1'b1, 1'b1); tick(1'b1, 1'b0);
      expect_lit(1, 8'h00); expect_lit(2, 8'h00);

      // read coincident with commit
      send_frame(8'h11, 1'b1, 1'b0, 1'b0);
      send_frame(8'h22, 1'b1, 1'b1, 1'b0);
      expect_lit(0, 8'h22); expect_lit(1, 8'h01); expect_lit(2, 8'h00);
      idle(3);

      // reset mid-DATA of 0xF0 while a byte is held
      for (int j = 0; j < 4 * C; j++) tick((j < C) ? 1'b0 : 1'b0, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      rx    = 1'b1;
      expect_lit(0, 8'h00); expect_lit(1, 8'h00); expect_lit(2, 8'h00);
      expect_lit(3, 8'h00); expect_lit(4, 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(5);
      send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
      expect_lit(0, 8'h0F); expect_lit(1, 8'h01);
      tick(1'b1, 1'b1); tick(1'b1, 1'b0);

      // randomized traffic with random reads, glitches and bad stop bits
      for (int n = 0; n < 40; n++) begin
         int gap;
         gap = $urandom_range(0, 12);
         for (int i = 0; i < gap; i++) tick(1'b1, $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 7) == 0) begin
            int gl;
            gl = $urandom_range(1, 6);
            for (int i = 0; i < gl; i++) tick(1'b0, 1'b0);
            idle(12);
         end
         begin
            logic [7:0] b;
            logic       sb;
            b  = 8'($urandom);
            sb = ($urandom_range(0, 7) != 0);
            send_frame(b, sb, 1'b0, 1'b1);
            if (!sb) begin
               int lo;
               lo = $urandom_range(0, 20);
               for (int i = 0; i < lo; i++) tick(1'b0, 1'b0);
            end
         end
      end
      idle(20);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b0);
      idle(3);

      @(negedge clk);
      #3;
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
